reg_bus_arbiter: RTL and testbench

- Single-clock, N-channel register-access arbiter.
- Each requester channel presents a write or read transaction with a level valid. The block grants channels round-robin and issues one single-cycle transaction at a time on a shared register bus.
- It waits for the bus acknowledge, or gives up after a programmable timeout, then returns a one-cycle ready pulse, read data and an error flag to the granted channel.
- It sits between the clock-domain-crossing handshake instances (already synchronised into the register clock) and the register file.

---
 rtl/reg_bus_arbiter_if.sv | 35 +++
 rtl/reg_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Bundle of requester-side and register-bus-side signals for reg_bus_arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface reg_bus_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 19
);
    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_write;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]        rsp_rdata;
    logic                         rsp_err;
    logic                         bus_valid;
    logic                         bus_write;
    logic [ADDR_WIDTH-1:0]        bus_addr;
    logic [DATA_WIDTH-1:0]        bus_wdata;
    logic                         bus_ack;
    logic [DATA_WIDTH-1:0]        bus_rdata;
    logic                         busy;
    logic [7:0]                   timeout_cnt;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_ack, bus_rdata,
        output req_ready, rsp_rdata, rsp_err, bus_valid, bus_write, bus_addr,
               bus_wdata, busy, timeout_cnt
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_ack, bus_rdata,
        input  req_ready, rsp_rdata, rsp_err, bus_valid, bus_write, bus_addr,
               bus_wdata, busy, timeout_cnt
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin N-channel register-access arbiter: one single-cycle bus transaction
// at a time, completion on bus_ack or after TIMEOUT wait cycles with an error flag.
module reg_bus_arbiter #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 19,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rstn,
    reg_bus_arbiter_if.master bif
);
    localparam int CW = $clog2(NUM_CH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] LP_ERR_DATA = DATA_WIDTH'(ERR_DATA);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_grant, w_grant;
    logic [CW-1:0]         r_last, w_last;
    logic [CW-1:0]         w_pick;
    logic                  w_found;
    logic [31:0]           w_idx;
    logic                  r_write, w_write;
    logic [WW-1:0]         r_wait, w_wait, w_wait_inc;
    logic [NUM_CH-1:0]     r_req_ready, w_req_ready;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
    logic                  r_rsp_err, w_rsp_err;
    logic                  r_bus_valid, w_bus_valid;
    logic                  r_bus_write, w_bus_write;
    logic [ADDR_WIDTH-1:0] r_bus_addr, w_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata, w_bus_wdata;
    logic                  r_busy, w_busy;
    logic [7:0]            r_tcnt, w_tcnt;

    // First asserted channel scanning upward from last+1 with wrap-around
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = (32'(r_last) + i + 32'd1) % NUM_CH;
            if (!w_found && bif.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = CW'(w_idx);
            end
        end
    end

    assign w_wait_inc = r_wait + 1'b1;

    // Every output is a register loaded from the next-cycle value computed here
    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_last      = r_last;
        w_write     = r_write;
        w_wait      = r_wait;
        w_req_ready = '0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_bus_valid = 1'b0;
        w_bus_write = 1'b0;
        w_bus_addr  = '0;
        w_bus_wdata = '0;
        w_tcnt      = r_tcnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = w_pick;
                    w_write     = bif.req_write[w_pick];
                    w_bus_valid = 1'b1;
                    w_bus_write = bif.req_write[w_pick];
                    w_bus_addr  = bif.req_addr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                    w_bus_wdata = bif.req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
                    w_state     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wait  = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                // Ack takes precedence over a timeout landing in the same cycle
                if (bif.bus_ack) begin
                    w_rsp_rdata          = r_write ? '0 : bif.bus_rdata;
                    w_rsp_err            = 1'b0;
                    w_req_ready[r_grant] = 1'b1;
                    w_state              = S_RESP;
                end else if (w_wait_inc == WW'(TIMEOUT)) begin
                    w_rsp_rdata          = LP_ERR_DATA;
                    w_rsp_err            = 1'b1;
                    w_req_ready[r_grant] = 1'b1;
                    w_state              = S_RESP;
                end else begin
                    w_wait = w_wait_inc;
                end
            end
            S_RESP: begin
                w_last = r_grant;
                if (r_rsp_err && (r_tcnt != 8'hFF)) begin
                    w_tcnt = r_tcnt + 8'd1;
                end
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last      <= CW'(NUM_CH - 1);
            r_write     <= 1'b0;
            r_wait      <= '0;
            r_req_ready <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_busy      <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_last      <= w_last;
            r_write     <= w_write;
            r_wait      <= w_wait;
            r_req_ready <= w_req_ready;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_bus_valid <= w_bus_valid;
            r_bus_write <= w_bus_write;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_busy      <= w_busy;
            r_tcnt      <= w_tcnt;
        end
    end

    assign bif.req_ready   = r_req_ready;
    assign bif.rsp_rdata   = r_rsp_rdata;
    assign bif.rsp_err     = r_rsp_err;
    assign bif.bus_valid   = r_bus_valid;
    assign bif.bus_write   = r_bus_write;
    assign bif.bus_addr    = r_bus_addr;
    assign bif.bus_wdata   = r_bus_wdata;
    assign bif.busy        = r_busy;
    assign bif.timeout_cnt = r_tcnt;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: table of single transactions plus hand-written
// sequences for reset-abort, round-robin contention and timeout-count saturation.
module tb_reg_bus_arbiter;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 19;
    localparam int TO = 16;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   cyc;
    int   exp_tcnt;

    reg_bus_arbiter_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    reg_bus_arbiter #(
        .NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bif (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        logic        w;
        logic [18:0] a;
        logic [31:0] wd;
        int          k;     // ack delay after bus_valid; 0 = never ack
        logic [31:0] brd;
        logic [3:0]  er;
        logic [31:0] erd;
        logic        ee;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_bus", {bif.bus_valid, bif.bus_write, bif.bus_addr, bif.bus_wdata}, '0);
        chk("rst_rsp", {bif.req_ready, bif.rsp_rdata, bif.rsp_err}, '0);
        chk("rst_tcnt", bif.timeout_cnt, 8'd0);
        @(negedge clk);
        rstn     = 1'b1;
        exp_tcnt = 0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the IDLE negedge after completion.
    task automatic run_txn(input int ch, input logic w, input logic [18:0] a, input logic [31:0] wd,
                           input int k, input logic [31:0] brd, input logic [3:0] er,
                           input logic [31:0] erd, input logic ee);
        int   L;
        logic early;
        bif.req_valid              = '0;
        bif.req_valid[ch]          = 1'b1;
        bif.req_write              = ~bif.req_valid;
        bif.req_write[ch]          = w;
        bif.req_addr               = {NC{19'h5A5A5}};
        bif.req_addr[ch*AW +: AW]  = a;
        bif.req_wdata              = {NC{32'h7777_1111}};
        bif.req_wdata[ch*DW +: DW] = wd;
        @(negedge clk);
        chk("bus_valid", bif.bus_valid, 1'b1);
        chk("bus_write", bif.bus_write, w);
        chk("bus_addr", bif.bus_addr, a);
        chk("bus_wdata", bif.bus_wdata, wd);
        bif.req_addr  = '1;
        bif.req_wdata = '1;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0BAD_0BAD;
        L     = (k > 0) ? k + 1 : TO + 1;
        early = 1'b0;
        for (int j = 1; j <= L; j++) begin
            @(negedge clk);
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'h3333_3333;
            if (j == 1) chk("bus_zero_after", {bif.bus_valid, bif.bus_write, bif.bus_addr, bif.bus_wdata}, '0);
            if (j < L && bif.req_ready != '0) early = 1'b1;
            if (j == k) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = brd;
            end
        end
        chk("no_early_ready", early, 1'b0);
        chk("req_ready", bif.req_ready, er);
        chk("rsp_rdata", bif.rsp_rdata, erd);
        chk("rsp_err", bif.rsp_err, ee);
        chk("busy_resp", bif.busy, 1'b1);
        bif.req_valid = '0;
        if (ee && exp_tcnt != 255) exp_tcnt++;
        @(negedge clk);
        chk("ready_pulse_end", bif.req_ready, 4'b0000);
        chk("busy_idle", bif.busy, 1'b0);
        chk("rsp_rdata_held", bif.rsp_rdata, erd);
        chk("timeout_cnt", bif.timeout_cnt, exp_tcnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   prev;
        logic got;
        total = 0;
        bad   = 0;
        exp_tcnt = 0;
        rstn = 1'b0;
        bif.req_valid = '0;
        bif.req_write = '0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;

        vt[0] = '{ch: 2, w: 1'b0, a: 19'h00123, wd: 32'h0,          k: 2,  brd: 32'hA5A5_0001,
                  er: 4'b0100, erd: 32'hA5A5_0001, ee: 1'b0};
        vt[1] = '{ch: 0, w: 1'b1, a: 19'h00010, wd: 32'h1234_5678,  k: 1,  brd: 32'hFFFF_0000,
                  er: 4'b0001, erd: 32'h0,         ee: 1'b0};
        vt[2] = '{ch: 1, w: 1'b0, a: 19'h00200, wd: 32'h0,          k: 0,  brd: 32'h0,
                  er: 4'b0010, erd: 32'hDEAD_BEEF, ee: 1'b1};
        vt[3] = '{ch: 3, w: 1'b0, a: 19'h40000, wd: 32'h0,          k: 16, brd: 32'h0BAD_F00D,
                  er: 4'b1000, erd: 32'h0BAD_F00D, ee: 1'b0};
        vt[4] = '{ch: 1, w: 1'b1, a: 19'h7FFFF, wd: 32'hCAFE_F00D,  k: 3,  brd: 32'h1111_2222,
                  er: 4'b0010, erd: 32'h0,         ee: 1'b0};

        do_reset();
        for (int v = 0; v < 5; v++) begin
            run_txn(vt[v].ch, vt[v].w, vt[v].a, vt[v].wd, vt[v].k, vt[v].brd, vt[v].er, vt[v].erd, vt[v].ee);
        end

        // Reset in WAIT aborts the transaction; pointer returns to channel 0
        bif.req_valid     = 4'b0100;
        bif.req_write     = '0;
        bif.req_addr      = '0;
        bif.req_addr[2*AW +: AW] = 19'h00BBB;
        @(negedge clk);
        chk("abort_bus_valid", bif.bus_valid, 1'b1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_busy", bif.busy, 1'b0);
        chk("abort_bus", {bif.bus_valid, bif.bus_write, bif.bus_addr, bif.bus_wdata}, '0);
        chk("abort_ready", bif.req_ready, 4'b0000);
        @(negedge clk);
        rstn          = 1'b1;
        exp_tcnt      = 0;
        bif.req_valid = '0;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h9999_9999;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        chk("stray_ack_busy", bif.busy, 1'b0);
        chk("stray_ack_ready", bif.req_ready, 4'b0000);
        chk("stray_ack_rdata", bif.rsp_rdata, 32'h0);
        bif.req_valid = 4'b0101;
        bif.req_addr[0 +: AW] = 19'h00AAA;
        @(negedge clk);
        chk("post_reset_grant", bif.bus_addr, 19'h00AAA);
        @(negedge clk);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0000_00C0;
        @(negedge clk);
        bif.bus_ack   = 1'b0;
        bif.req_valid = '0;
        chk("post_reset_ready", bif.req_ready, 4'b0001);
        @(negedge clk);

        // All channels held valid: order 0,1,2,3,0 with 4-cycle spacing
        do_reset();
        bif.req_valid = '1;
        bif.req_write = '0;
        for (int c = 0; c < NC; c++) bif.req_addr[c*AW +: AW] = 19'(32'h100 + c);
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (bif.bus_valid) got = 1'b1;
            end
            chk("rr_bus_valid_seen", got, 1'b1);
            if (!got) break;
            chk("rr_grant", bif.bus_addr, 19'(32'h100 + (n % 4)));
            if (n > 0) chk("rr_spacing", 64'(cyc - prev), 64'd4);
            prev = cyc;
            @(negedge clk);
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = 32'h5000_0000 + 32'(n);
            @(negedge clk);
            bif.bus_ack = 1'b0;
            chk("rr_ready", bif.req_ready, 4'b0001 << (n % 4));
            chk("rr_rdata", bif.rsp_rdata, 32'h5000_0000 + 32'(n));
            if (n == 4) bif.req_valid = '0;
        end
        @(negedge clk);

        // Timeout counter saturates at 255
        for (int s = 0; s < 258; s++) begin
            run_txn(s % 4, 1'b0, 19'(s), 32'h0, 0, 32'h0, 4'b0001 << (s % 4), 32'hDEAD_BEEF, 1'b1);
        end
        chk("tcnt_saturated", bif.timeout_cnt, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
